// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM encoding for the input debouncer; bit 1 is dout, bit 0 is settling.
package debounce_pkg;
    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'b00,
        ST_WAIT_HI   = 2'b01,
        ST_STABLE_HI = 2'b10,
        ST_WAIT_LO   = 2'b11
    } state_t;
    function automatic state_t reset_state(input logic v);
        return v ? ST_STABLE_HI : ST_STABLE_LO;
    endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: N-stage flop synchronizer for bringing an asynchronous bit into the clk domain.
module sync_ff #(
    parameter int   N         = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [N-1:0] s;
    always_ff @(posedge clk) begin
        if (rst) s <= {N{RESET_VAL}};
        else     s <= {s[N-2:0], d};
    end
    assign q = s[N-1];
endmodule

// File: rtl/din_debounce.sv
// din_debounce: synchronizes a raw bouncing input and accepts a new level only after it holds
// for DEBOUNCE_CYCLES+1 consecutive samples; reports settling and rejected transitions.
module din_debounce
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter int   CNT_WIDTH       = 16,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic settling,
    output logic glitch
);
    localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    logic din_sync;
    state_t state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic glitch_n;
    sync_ff #(.N(SYNC_STAGES), .RESET_VAL(RESET_VAL)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (din),
        .q  (din_sync)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= reset_state(RESET_VAL);
            cnt    <= '0;
            glitch <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            glitch <= glitch_n;
        end
    end
    // Abort is tested before terminal count so a revert on the last sample still rejects.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        glitch_n = 1'b0;
        case (state)
            ST_STABLE_LO: if (din_sync) begin
                state_n = ST_WAIT_HI;
                cnt_n   = '0;
            end
            ST_WAIT_HI: if (!din_sync) begin
                state_n  = ST_STABLE_LO;
                cnt_n    = '0;
                glitch_n = 1'b1;
            end else if (cnt == TERM) begin
                state_n = ST_STABLE_HI;
                cnt_n   = '0;
            end else cnt_n = cnt + 1'b1;
            ST_STABLE_HI: if (!din_sync) begin
                state_n = ST_WAIT_LO;
                cnt_n   = '0;
            end
            ST_WAIT_LO: if (din_sync) begin
                state_n  = ST_STABLE_HI;
                cnt_n    = '0;
                glitch_n = 1'b1;
            end else if (cnt == TERM) begin
                state_n = ST_STABLE_LO;
                cnt_n   = '0;
            end else cnt_n = cnt + 1'b1;
            default: state_n = reset_state(RESET_VAL);
        endcase
    end
    assign dout     = state[1];
    assign settling = state[0];
endmodule

// File: tb/tb_din_debounce.sv
// tb_din_debounce: directed checks of two debouncer configurations against hand-derived timing.
module tb_din_debounce;
    logic clk = 1'b0;
    logic rst0, din0, dout0, set0, gl0;
    logic rst1, din1, dout1, set1, gl1;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    din_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(16), .RESET_VAL(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .din(din0), .dout(dout0), .settling(set0), .glitch(gl0)
    );
    din_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(16), .RESET_VAL(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .din(din1), .dout(dout1), .settling(set1), .glitch(gl1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic d, input logic s, input logic g);
        checks++;
        assert (dout0 === d) else begin
            errors++;
            $error("FAIL %s dout got %b exp %b", tag, dout0, d);
        end
        checks++;
        assert (set0 === s) else begin
            errors++;
            $error("FAIL %s settling got %b exp %b", tag, set0, s);
        end
        checks++;
        assert (gl0 === g) else begin
            errors++;
            $error("FAIL %s glitch got %b exp %b", tag, gl0, g);
        end
    endtask

    task automatic chk1(input string tag, input logic d, input logic s, input logic g);
        checks++;
        assert (dout1 === d) else begin
            errors++;
            $error("FAIL %s dout got %b exp %b", tag, dout1, d);
        end
        checks++;
        assert (set1 === s) else begin
            errors++;
            $error("FAIL %s settling got %b exp %b", tag, set1, s);
        end
        checks++;
        assert (gl1 === g) else begin
            errors++;
            $error("FAIL %s glitch got %b exp %b", tag, gl1, g);
        end
    endtask

    initial begin
        rst0 = 1'b1; din0 = 1'b0;
        rst1 = 1'b1; din1 = 1'b1;
        step();
        step();
        chk0("reset0", 1'b0, 1'b0, 1'b0);
        chk1("reset1", 1'b1, 1'b0, 1'b0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        // 1: idle low
        for (int k = 1; k <= 20; k++) begin
            step();
            chk0($sformatf("idle k%0d", k), 1'b0, 1'b0, 1'b0);
        end
        // 2: clean rise, dout after E7
        din0 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk0($sformatf("rise k%0d", k), k >= 7, k >= 3 && k <= 6, 1'b0);
        end
        // clean fall back to low
        din0 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk0($sformatf("fall k%0d", k), k < 7, k >= 3 && k <= 6, 1'b0);
        end
        // 3: two-cycle pulse rejected
        din0 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk0($sformatf("short k%0d", k), 1'b0, k == 3 || k == 4, k == 5);
            if (k == 2) din0 = 1'b0;
        end
        // abort on the terminal-count sample: four highs then low
        din0 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk0($sformatf("term k%0d", k), 1'b0, k >= 3 && k <= 6, k == 7);
            if (k == 4) din0 = 1'b0;
        end
        // 4: bounce 1,0,1,0 then hold 1
        for (int k = 1; k <= 12; k++) begin
            din0 = (k == 2 || k == 4) ? 1'b0 : 1'b1;
            step();
            chk0($sformatf("bounce k%0d", k), k >= 11,
                 k == 3 || k == 5 || (k >= 7 && k <= 10), k == 4 || k == 6);
        end
        din0 = 1'b0;
        repeat (7) step();
        chk0("bounce_back", 1'b0, 1'b0, 1'b0);
        // 5: reset during WAIT_HI
        din0 = 1'b1;
        repeat (3) step();
        chk0("pre_rst", 1'b0, 1'b1, 1'b0);
        rst0 = 1'b1;
        step();
        chk0("in_rst", 1'b0, 1'b0, 1'b0);
        rst0 = 1'b0;
        for (int k = 5; k <= 11; k++) begin
            step();
            chk0($sformatf("post_rst e%0d", k), k >= 11, k >= 7 && k <= 10, 1'b0);
        end
        // 6: RESET_VAL=1, DEBOUNCE_CYCLES=1 clean fall
        chk1("dut1_idle", 1'b1, 1'b0, 1'b0);
        din1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk1($sformatf("dut1 k%0d", k), k < 4, k == 3, 1'b0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
